// File: rtl/jpeg_pkg.sv
// Shared constants and FSM state type for the JPEG front-end image readers.
// The block geometry lives here so every reader agrees on the 8x8 walk.
package jpeg_pkg;

   localparam int BLK_DIM      = 8;
   localparam int PIX_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/image_block_reader_if.sv
// Word stream from the block reader to the downstream DCT/level-shift stage.
// valid/ready: a word transfers on a clock edge where out_valid & out_ready are both high; once out_valid rises, it and out_data/tags hold until that transfer.
interface image_block_reader_if #(
   parameter int DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_blk_last;
   logic                  out_frame_last;

   modport master (
      output out_data,
      output out_valid,
      output out_blk_last,
      output out_frame_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_blk_last,
      input  out_frame_last,
      output out_ready
   );

endinterface

// File: rtl/word_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM read latency so the stream can stall
// without losing the word already in flight.
module word_skid_fifo #(
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [1:0]       count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] slot_q [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i && (count_q != 2'd2);
   assign pop_ok  = pop_i && (count_q != 2'd0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + 2'(push_ok) - 2'(pop_ok);
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q[0] <= '0;
         slot_q[1] <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push_ok) slot_q[wr_ptr_q] <= push_data_i;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = slot_q[rd_ptr_q];

endmodule

// File: rtl/image_block_reader.sv
// Walks the raster image RAM in 8x8 block order and streams the words out
// over a valid/ready link; reads are only issued when the FIFO has room.
module image_block_reader
   import jpeg_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 16,
   parameter int WORDS_PER_ROW = 128,
   parameter int ROWS          = 512,
   parameter int BLK_WORDS     = BLK_DIM / PIX_PER_WORD
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_q,
   image_block_reader_if.master  out_if,
   output rd_state_t             dbg_state_o
);

   localparam int W_W    = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam int R_W    = $clog2(BLK_DIM);
   localparam int BC_N   = WORDS_PER_ROW / BLK_WORDS;
   localparam int BC_W   = (BC_N > 1) ? $clog2(BC_N) : 1;
   localparam int BR_N   = ROWS / BLK_DIM;
   localparam int BR_W   = (BR_N > 1) ? $clog2(BR_N) : 1;
   localparam int ROW_SH = $clog2(WORDS_PER_ROW);
   localparam int COL_SH = $clog2(BLK_WORDS);
   localparam int TW     = DATA_WIDTH + 2;

   rd_state_t       state_q, state_d;
   logic [W_W-1:0]  w_q, w_d;
   logic [R_W-1:0]  r_q, r_d;
   logic [BC_W-1:0] bc_q, bc_d;
   logic [BR_W-1:0] br_q, br_d;
   logic            inflight_q;
   logic            blk_tag_q;
   logic            frame_tag_q;
   logic            done_q, done_d;

   logic            w_last, r_last, bc_last, br_last;
   logic            blk_end, frame_end;
   logic            pop, issue;
   logic [2:0]      occupancy;
   logic [1:0]      fifo_count;
   logic [TW-1:0]   fifo_head;

   assign w_last    = (w_q == W_W'(BLK_WORDS - 1));
   assign r_last    = (r_q == R_W'(BLK_DIM - 1));
   assign bc_last   = (bc_q == BC_W'(BC_N - 1));
   assign br_last   = (br_q == BR_W'(BR_N - 1));
   assign blk_end   = w_last && r_last;
   assign frame_end = blk_end && bc_last && br_last;

   // Count the word in flight from the RAM so a stalled stream never overflows the FIFO.
   assign pop       = out_if.out_valid & out_if.out_ready;
   assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
   assign issue     = (state_q == RUN) && (occupancy < 3'd2);

   always_comb begin
      w_d  = w_q;
      r_d  = r_q;
      bc_d = bc_q;
      br_d = br_q;
      if (issue) begin
         w_d = w_last ? '0 : w_q + 1'b1;
         if (w_last) begin
            r_d = r_last ? '0 : r_q + 1'b1;
            if (r_last) begin
               bc_d = bc_last ? '0 : bc_q + 1'b1;
               if (bc_last) br_d = br_last ? '0 : br_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = RUN;
         RUN:   if (issue && frame_end) state_d = DRAIN;
         DRAIN: begin
            // Leave as the last buffered word is accepted, so done lines up with that edge.
            if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         w_q         <= '0;
         r_q         <= '0;
         bc_q        <= '0;
         br_q        <= '0;
         inflight_q  <= 1'b0;
         blk_tag_q   <= 1'b0;
         frame_tag_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         r_q         <= r_d;
         bc_q        <= bc_d;
         br_q        <= br_d;
         inflight_q  <= issue;
         blk_tag_q   <= issue && blk_end;
         frame_tag_q <= issue && frame_end;
         done_q      <= done_d;
      end
   end

   // Row index {br, r} scaled by the row pitch, plus the block column offset and word.
   assign rd_addr = (ADDR_WIDTH'({br_q, r_q}) << ROW_SH)
                  | (ADDR_WIDTH'(bc_q) << COL_SH)
                  | ADDR_WIDTH'(w_q);

   word_skid_fifo #(
      .WIDTH (TW)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i ({frame_tag_q, blk_tag_q, mem_q}),
      .pop_i       (pop),
      .count_o     (fifo_count),
      .head_o      (fifo_head)
   );

   assign out_if.out_valid      = (fifo_count != 2'd0);
   assign out_if.out_data       = fifo_head[DATA_WIDTH-1:0];
   assign out_if.out_blk_last   = fifo_head[DATA_WIDTH];
   assign out_if.out_frame_last = fifo_head[DATA_WIDTH+1];

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_image_block_reader.sv
// Bench for image_block_reader: a small 4x16-word image under several
// ready/start/reset patterns, then one full frame at default geometry.
module tb_image_block_reader;
   import jpeg_pkg::*;

   localparam int DW      = 32;
   localparam int AW      = 16;
   localparam int S_WPR   = 4;
   localparam int S_ROWS  = 16;
   localparam int S_BW    = 2;
   localparam int S_WORDS = S_WPR * S_ROWS;
   localparam int D_WPR   = 128;
   localparam int D_ROWS  = 512;
   localparam int D_BW    = 2;
   localparam int D_WORDS = D_WPR * D_ROWS;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: k-th word of an 8x8 block-order walk over a raster image.
   function automatic logic [DW-1:0] blk_order_addr(input int k, input int wpr, input int bw);
      int w, r, bc, br;
      w  = k % bw;
      r  = (k / bw) % BLK_DIM;
      bc = (k / (bw * BLK_DIM)) % (wpr / bw);
      br = k / (BLK_DIM * wpr);
      return DW'((br * BLK_DIM + r) * wpr + bc * bw + w);
   endfunction

   // ---------------- small instance ----------------
   logic            a_start;
   logic            a_busy, a_done;
   logic [AW-1:0]   a_addr;
   logic [DW-1:0]   a_mem;
   rd_state_t       a_state;
   image_block_reader_if #(.DATA_WIDTH(DW)) a_if ();

   image_block_reader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_ROW(S_WPR), .ROWS(S_ROWS), .BLK_WORDS(S_BW)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
      .rd_addr(a_addr), .mem_q(a_mem), .out_if(a_if), .dbg_state_o(a_state)
   );

   always_ff @(posedge clk) a_mem <= DW'(a_addr);

   // ---------------- default-geometry instance ----------------
   logic            b_start;
   logic            b_busy, b_done;
   logic [AW-1:0]   b_addr;
   logic [DW-1:0]   b_mem;
   rd_state_t       b_state;
   image_block_reader_if #(.DATA_WIDTH(DW)) b_if ();

   image_block_reader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_ROW(D_WPR), .ROWS(D_ROWS), .BLK_WORDS(D_BW)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
      .rd_addr(b_addr), .mem_q(b_mem), .out_if(b_if), .dbg_state_o(b_state)
   );

   always_ff @(posedge clk) b_mem <= DW'(b_addr);

   // ---------------- scoreboard, small instance ----------------
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [1:0]    exp_tag_q[$];
   logic [1:0]    model_tag_q[$];
   logic [DW-1:0] a_e;
   logic [1:0]    a_t;
   logic [DW-1:0] prev_data = '0;
   bit            a_mon = 1'b0;
   bit            prev_stall = 1'b0;
   int            a_acc = 0, a_done_cnt = 0, cyc = 0, first_acc = 0, last_acc = 0;

   always @(negedge clk) begin
      cyc++;
      if (!a_mon) begin
         exp_q      = model_q;
         exp_tag_q  = model_tag_q;
         a_acc      = 0;
         a_done_cnt = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", a_if.out_valid, 1);
            check("hold_data", a_if.out_data, prev_data);
         end
         prev_stall = a_if.out_valid && !a_if.out_ready;
         prev_data  = a_if.out_data;
         if (a_if.out_valid && a_if.out_ready) begin
            if (exp_q.size() != 0) begin
               a_e = exp_q.pop_front();
               a_t = exp_tag_q.pop_front();
               check("data", a_if.out_data, a_e);
               check("blk_last", a_if.out_blk_last, a_t[0]);
               check("frame_last", a_if.out_frame_last, a_t[1]);
            end
            a_acc++;
            if (a_acc == 1) first_acc = cyc;
            last_acc = cyc;
         end
         if (a_done) begin
            a_done_cnt++;
            check("busy_at_done", a_busy, 0);
            check("words_at_done", a_acc, S_WORDS);
         end
      end
   end

   // ---------------- monitor, default instance ----------------
   bit            b_mon = 1'b0;
   int            b_acc = 0, b_done_cnt = 0, b_zero_cnt = 0;
   logic [DW-1:0] b_last_addr = '0;

   always @(negedge clk) begin
      if (b_mon) begin
         if (b_if.out_valid && b_if.out_ready) begin
            check("big_data", b_if.out_data, blk_order_addr(b_acc, D_WPR, D_BW));
            check("big_frame_last", b_if.out_frame_last, b_acc == D_WORDS - 1);
            if (b_if.out_data == '0) b_zero_cnt++;
            b_last_addr = b_if.out_data;
            b_acc++;
         end
         if (b_done) b_done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic rearm();
      a_mon = 1'b0;
      @(negedge clk);
      #1 a_mon = 1'b1;
   endtask

   task automatic start_frame();
      @(posedge clk); #1;
      check("pre_start_busy", a_busy, 0);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      check("start_busy", a_busy, 1);
      check("start_valid_n1", a_if.out_valid, 0);
      @(posedge clk); #1;
      check("start_valid_n2", a_if.out_valid, 0);
      @(posedge clk); #1;
      check("first_valid", a_if.out_valid, 1);
      check("first_data", a_if.out_data, 0);
   endtask

   task automatic run_until_done(input int budget, input bit rnd_ready, input bit noise);
      int n = 0;
      while (a_done_cnt == 0 && n < budget) begin
         @(posedge clk); #1;
         a_if.out_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
         a_start = noise && a_busy && ($urandom_range(0, 99) < 5);
         n++;
      end
      a_start = 1'b0;
      a_if.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic frame_checks(input string tag);
      check({tag, "_words"}, a_acc, S_WORDS);
      check({tag, "_done_once"}, a_done_cnt, 1);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      check({tag, "_state"}, 32'(a_state), 32'(IDLE));
      check({tag, "_valid_low"}, a_if.out_valid, 0);
   endtask

   task automatic check_a_idle(input string tag);
      check({tag, "_busy"}, a_busy, 0);
      check({tag, "_done"}, a_done, 0);
      check({tag, "_rd_addr"}, a_addr, 0);
      check({tag, "_valid"}, a_if.out_valid, 0);
      check({tag, "_data"}, a_if.out_data, 0);
      check({tag, "_blk_last"}, a_if.out_blk_last, 0);
      check({tag, "_frame_last"}, a_if.out_frame_last, 0);
      check({tag, "_state"}, 32'(a_state), 32'(IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int k = 0; k < S_WORDS; k++) begin
         model_q.push_back(blk_order_addr(k, S_WPR, S_BW));
         model_tag_q.push_back({k == S_WORDS - 1, ((k + 1) % (S_BW * BLK_DIM)) == 0});
      end

      rst_n = 1'b0;
      a_start = 1'b0;
      b_start = 1'b0;
      a_if.out_ready = 1'b0;
      b_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_a_idle("reset");
      check("reset_b_valid", b_if.out_valid, 0);
      check("reset_b_addr", b_addr, 0);
      rst_n = 1'b1;

      // Full frame with the stream always ready.
      a_if.out_ready = 1'b1;
      rearm();
      start_frame();
      run_until_done(400, 1'b0, 1'b0);
      frame_checks("full");
      check("full_back_to_back", last_acc - first_acc, S_WORDS - 1);

      // Random 30% ready with stray start pulses while busy.
      a_if.out_ready = 1'b0;
      rearm();
      start_frame();
      run_until_done(3000, 1'b1, 1'b1);
      frame_checks("random");

      // Reset right after the 10th accepted word, then a fresh frame.
      a_if.out_ready = 1'b1;
      rearm();
      start_frame();
      begin
         int n = 0;
         while (a_acc < 10 && n < 200) begin
            @(posedge clk); #1;
            n++;
         end
      end
      check("acc_before_reset", a_acc, 10);
      a_mon = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_a_idle("midreset");
      repeat (3) @(posedge clk);
      #1;
      check("midreset_stays_idle", 32'(a_state), 32'(IDLE));
      check("midreset_no_done", a_done, 0);
      rearm();
      start_frame();
      run_until_done(400, 1'b0, 1'b0);
      frame_checks("restart");

      // One frame at default geometry: whole address space, no early wrap.
      b_mon = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      begin
         int n = 0;
         while (b_done_cnt == 0 && n < D_WORDS + 500) begin
            @(posedge clk); #1;
            n++;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check("big_words", b_acc, D_WORDS);
      check("big_done_once", b_done_cnt, 1);
      check("big_last_addr", b_last_addr, 32'(D_WORDS - 1));
      check("big_zero_once", b_zero_cnt, 1);
      check("big_idle", b_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/image_block_reader.md
# image_block_reader

Read sequencer for the image word RAM. The RAM is a 32-bit × 2^ADDR_WIDTH simple dual-port memory with 1-cycle registered read. On `start`, the block walks the stored raster image in 8×8 pixel-block order: block rows top to bottom, block columns left to right, and within a block, row by row. It drives the RAM read address and streams the returned words to the downstream DCT/level-shift stage over a valid/ready interface with full backpressure.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM word width (4 pixels per word).
- ADDR_WIDTH, 16, RAM address width.
- WORDS_PER_ROW, 128, words per image row; power of two.
- ROWS, 512, image rows; multiple of 8.
- BLK_WORDS, 2, words per block row (8 pixels / 4 per word); power of two; divides WORDS_PER_ROW.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to read one full frame; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle pulse after the final word is accepted downstream.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- mem_q  in  DATA_WIDTH  RAM read data, valid one cycle after the address.
- out_data  out  DATA_WIDTH  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when high together with out_valid.
- out_blk_last  out  1  qualifies the last word of each 8×8 block.
- out_frame_last  out  1  qualifies the last word of the frame.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN when start = 1.
  - RUN → DRAIN after the final address is issued.
  - DRAIN → IDLE when the FIFO and in-flight flag are both empty. done pulses on this transition.
- Counters:
  - w: 0..BLK_WORDS-1.
  - r: 0..7.
  - bc: 0..WORDS_PER_ROW/BLK_WORDS-1.
  - br: 0..ROWS/8-1.
  - Nesting is w innermost, then r, bc, br. Each counter wraps to 0 and carries into the next.
- Address: rd_addr = ((br·8 + r)·WORDS_PER_ROW) + bc·BLK_WORDS + w, truncated to ADDR_WIDTH. It is formed with shifts and concatenation only; no multipliers.
- Read issue:
  - A read is issued in a RUN cycle iff (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
  - Counters advance only on issue. rd_addr holds while stalled.
- inflight register: set on issue, cleared the next cycle. When it is set, mem_q is written into a 2-entry output FIFO together with the blk_last and frame_last tags computed at issue time.
- Output: out_data, out_valid and the tags come from the FIFO head.
  - The FIFO can never overflow.
  - out_valid never drops without a pop.
  - out_data is stable while out_valid & ~out_ready.
- start while busy: no effect.
- Reset, asserted at any time including mid-frame, forces IDLE, clears the counters, FIFO and inflight, and discards in-flight data.
- Total words per frame: WORDS_PER_ROW·ROWS. Default is 65536 words, which fills the full address space.

## Timing
- Reset values: busy = 0, done = 0, rd_addr = 0, out_valid = 0, out_data = 0, out_blk_last = 0, out_frame_last = 0.
- start sampled at edge N:
  - state = RUN after N; first address 0 is issued in cycle N..N+1.
  - mem_q is valid after N+1.
  - FIFO write at N+2; out_valid = 1 after N+2.
- With out_ready held high, throughput is 1 word per cycle with no bubbles.
- Last word accepted at edge M → done = 1 and busy = 0 during cycle M..M+1.
- out_ready low for k cycles → at most 2 words are buffered. Issue resumes so that throughput returns to 1 word per cycle on the second cycle after out_ready rises.

## Structure
- Package jpeg_pkg:
  - BLK_DIM = 8.
  - PIX_PER_WORD = 4.
  - State enum rd_state_t {IDLE, RUN, DRAIN}.
- Sub-module word_skid_fifo: 2-entry FIFO of width DATA_WIDTH+2 with push, pop, count, and head outputs.
- The counter and address generator stay in the top module.

## Test plan
Bench parameters: WORDS_PER_ROW = 4, ROWS = 16, BLK_WORDS = 2 (64 words, 4 blocks). The RAM model returns data equal to its address.

- Full frame, out_ready = 1 → out_data sequence begins 0,1,4,5,8,9,…,28,29 (block 0), then 2,3,6,7,…,30,31, then 32,33,36,… and ends at 63.
  - out_blk_last is high on 29, 31, 61, 63.
  - out_frame_last is high only on 63.
  - 64 words are accepted in 64 consecutive cycles.
  - done pulses exactly once.
- start at edge N → out_valid first high after N+2 with out_data = 0; busy high from N+1.
- Random out_ready at 30% high → identical sequence, no drops or duplicates; out_data stable whenever out_valid & ~out_ready.
- start pulsed mid-frame → sequence unchanged; one done only.
- rst_n low for 1 cycle after the 10th accepted word → all outputs 0 next cycle, state IDLE. A new start restarts from address 0.
- Default parameters, one frame → 65536 words; the last address is 65535, with no address wrap to 0 before the end.
